// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/pipeline-flow controller sequencing CSR updates ahead of pc_reg redirects
module trap_ctrl #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic            mret_i,
    input  logic            int_req_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic            jump_flag_ex_i,
    input  logic [XLEN-1:0] jump_addr_ex_i,
    input  logic            hold_ex_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    output logic            csr_we_o,
    output logic [XLEN-1:0] csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            csr_busy_o,
    output logic            hold_flag_o,
    output logic            jump_flag_o,
    output logic [XLEN-1:0] jump_addr_o
);

    localparam logic [XLEN-1:0] ADDR_MSTATUS = XLEN'(12'h300);
    localparam logic [XLEN-1:0] ADDR_MEPC    = XLEN'(12'h341);
    localparam logic [XLEN-1:0] ADDR_MCAUSE  = XLEN'(12'h342);
    localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(32'd11);
    localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(32'd3);
    localparam logic [XLEN-1:0] CAUSE_INT    = XLEN'(32'h8000_000B);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_STATUS,
        RET_STATUS,
        JUMP
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] epc_q, cause_q;
    logic            ret_q;

    logic take_ecall, take_ebreak, take_mret, take_int;
    logic is_idle, accept_trap, accept_ret, accept;

    always_comb begin
        take_ecall  = ecall_i;
        take_ebreak = ebreak_i & ~ecall_i;
        take_mret   = mret_i & ~ecall_i & ~ebreak_i;
        take_int    = int_req_i & csr_mstatus_i[3] & ~hold_ex_i
                    & ~ecall_i & ~ebreak_i & ~mret_i;
        is_idle     = (state == IDLE);
        accept_trap = is_idle & (take_ecall | take_ebreak | take_int);
        accept_ret  = is_idle & take_mret;
        accept      = accept_trap | accept_ret;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            ret_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_trap) begin
                ret_q <= 1'b0;
                // An interrupt resumes at the instruction that would have run next.
                if (take_int) begin
                    epc_q   <= jump_flag_ex_i ? jump_addr_ex_i : inst_addr_i + XLEN'(4);
                    cause_q <= CAUSE_INT;
                end else begin
                    epc_q   <= inst_addr_i;
                    cause_q <= take_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                end
            end else if (accept_ret) begin
                ret_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        case (state)
            IDLE: begin
                if (accept_trap) begin
                    state_nxt = SAVE_EPC;
                end else if (accept_ret) begin
                    state_nxt = RET_STATUS;
                end else begin
                    jump_flag_o = jump_flag_ex_i;
                    jump_addr_o = jump_addr_ex_i;
                end
            end
            SAVE_EPC: begin
                state_nxt   = SAVE_CAUSE;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = epc_q;
            end
            SAVE_CAUSE: begin
                state_nxt   = SAVE_STATUS;
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            SAVE_STATUS: begin
                state_nxt      = JUMP;
                csr_we_o       = 1'b1;
                csr_waddr_o    = ADDR_MSTATUS;
                csr_wdata_o    = csr_mstatus_i;
                csr_wdata_o[7] = csr_mstatus_i[3];
                csr_wdata_o[3] = 1'b0;
            end
            RET_STATUS: begin
                state_nxt      = JUMP;
                csr_we_o       = 1'b1;
                csr_waddr_o    = ADDR_MSTATUS;
                csr_wdata_o    = csr_mstatus_i;
                csr_wdata_o[3] = csr_mstatus_i[7];
                csr_wdata_o[7] = 1'b1;
            end
            JUMP: begin
                // CSR writes from the previous states are already visible on the taps here.
                state_nxt   = IDLE;
                jump_flag_o = 1'b1;
                jump_addr_o = ret_q ? csr_mepc_i : (csr_mtvec_i & MTVEC_MASK);
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign csr_busy_o  = ~is_idle;
    assign hold_flag_o = hold_ex_i | (~is_idle & (state != JUMP)) | accept;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - table-driven self-checking bench for trap_ctrl
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_i, ebreak_i, mret_i, int_req_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_ex_i;
    logic [31:0] jump_addr_ex_i;
    logic        hold_ex_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o, csr_wdata_o;
    logic        csr_busy_o, hold_flag_o, jump_flag_o;
    logic [31:0] jump_addr_o;

    int passed = 0;
    int total  = 0;

    trap_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ecall_i       (ecall_i),
        .ebreak_i      (ebreak_i),
        .mret_i        (mret_i),
        .int_req_i     (int_req_i),
        .inst_addr_i   (inst_addr_i),
        .jump_flag_ex_i(jump_flag_ex_i),
        .jump_addr_ex_i(jump_addr_ex_i),
        .hold_ex_i     (hold_ex_i),
        .csr_mtvec_i   (csr_mtvec_i),
        .csr_mepc_i    (csr_mepc_i),
        .csr_mstatus_i (csr_mstatus_i),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_busy_o    (csr_busy_o),
        .hold_flag_o   (hold_flag_o),
        .jump_flag_o   (jump_flag_o),
        .jump_addr_o   (jump_addr_o)
    );

    always #5 clk = ~clk;

    // exp packs {we, waddr, wdata, busy, hold, jump_flag, jump_addr}
    typedef struct {
        logic        e, b, m, i, h, jf;
        logic [31:0] ja, inst, mtvec, mepc, mst;
        logic [99:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic e, b, m, i, h, jf,
                                input logic [31:0] ja, inst, mtvec, mepc, mst,
                                input logic ewe, input logic [31:0] ewa, ewd,
                                input logic ebusy, ehold, ejf, input logic [31:0] eja);
        vec_t v;
        v.e = e; v.b = b; v.m = m; v.i = i; v.h = h; v.jf = jf;
        v.ja = ja; v.inst = inst; v.mtvec = mtvec; v.mepc = mepc; v.mst = mst;
        v.exp = {ewe, ewa, ewd, ebusy, ehold, ejf, eja};
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [99:0] exp);
        logic [99:0] got;
        got = {csr_we_o, csr_waddr_o, csr_wdata_o, csr_busy_o, hold_flag_o, jump_flag_o, jump_addr_o};
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got we/waddr/wdata/busy/hold/jf/ja=%h required %h", name, got, exp);
    endtask

    task automatic drive(input vec_t v);
        ecall_i = v.e; ebreak_i = v.b; mret_i = v.m; int_req_i = v.i; hold_ex_i = v.h;
        jump_flag_ex_i = v.jf; jump_addr_ex_i = v.ja; inst_addr_i = v.inst;
        csr_mtvec_i = v.mtvec; csr_mepc_i = v.mepc; csr_mstatus_i = v.mst;
    endtask

    task automatic run_range(input string tag, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            drive(vq[k]);
            #1;
            check($sformatf("%s[%0d]", tag, k), vq[k].exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ecall_i = 0; ebreak_i = 0; mret_i = 0; int_req_i = 0; hold_ex_i = 0;
        jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h1234; inst_addr_i = 0;
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
        #2;
        check("reset_passthru", {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234});
        @(negedge clk);
        jump_flag_ex_i = 1'b0; jump_addr_ex_i = 0;
        rst = 1'b0;

        //  e b m i h jf  ja          inst          mtvec   mepc   mst      we wa      wd              bsy hld jf ja
        // ecall with coincident EX jump (suppressed), ebreak in JUMP dropped, mtvec mask
        add(1,0,0,0,0,1, 32'h300,     32'h40,       32'h100,32'h0, 32'h8,   0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h0, 32'h8,   1,32'h341,32'h40,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h40,32'h8,   1,32'h342,32'd11,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h40,32'h8,   1,32'h300,32'h80,         1,1,0,32'h0);
        add(0,1,0,0,0,0, 32'h0,       32'h40,       32'h103,32'h40,32'h80,  0,32'h0,  32'h0,          1,0,1,32'h100);
        add(0,0,0,0,0,1, 32'h500,     32'h100,      32'h100,32'h40,32'h80,  0,32'h0,  32'h0,          0,0,1,32'h500);
        // mret (interrupt masked alongside), interrupt in JUMP dropped
        add(0,0,1,1,0,0, 32'h0,       32'h104,      32'h100,32'h44,32'h80,  0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h104,      32'h100,32'h44,32'h80,  1,32'h300,32'h88,         1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h104,      32'h100,32'h44,32'h88,  0,32'h0,  32'h0,          1,0,1,32'h44);
        // interrupt with coincident EX jump
        add(0,0,0,1,0,1, 32'h200,     32'h1000,     32'h100,32'h44,32'h88,  0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h1000,     32'h100,32'h44,32'h88,  1,32'h341,32'h200,        1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h1000,     32'h100,32'h200,32'h88, 1,32'h342,32'h8000000B,   1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h1000,     32'h100,32'h200,32'h88, 1,32'h300,32'h80,         1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h1000,     32'h100,32'h200,32'h80, 0,32'h0,  32'h0,          1,0,1,32'h100);
        add(0,0,0,1,0,0, 32'h0,       32'h100,      32'h100,32'h200,32'h80, 0,32'h0,  32'h0,          0,0,0,32'h0);
        // interrupt blocked by hold_ex, then taken without EX jump
        add(0,0,0,1,1,1, 32'h600,     32'h2000,     32'h100,32'h200,32'h88, 0,32'h0,  32'h0,          0,1,1,32'h600);
        add(0,0,0,1,0,0, 32'h0,       32'h2000,     32'h100,32'h200,32'h88, 0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h2000,     32'h100,32'h200,32'h88, 1,32'h341,32'h2004,       1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h2000,     32'h100,32'h2004,32'h88,1,32'h342,32'h8000000B,   1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h2000,     32'h100,32'h2004,32'h88,1,32'h300,32'h80,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h2000,     32'h100,32'h2004,32'h80,0,32'h0,  32'h0,          1,0,1,32'h100);
        // ecall and interrupt together: ecall wins, interrupt then masked
        add(1,0,0,1,0,0, 32'h0,       32'h300,      32'h100,32'h0, 32'h88,  0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h300,      32'h100,32'h0, 32'h88,  1,32'h341,32'h300,        1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h300,      32'h100,32'h300,32'h88, 1,32'h342,32'd11,         1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h300,      32'h100,32'h300,32'h88, 1,32'h300,32'h80,         1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'h300,      32'h100,32'h300,32'h80, 0,32'h0,  32'h0,          1,0,1,32'h100);
        add(0,0,0,1,0,0, 32'h0,       32'h100,      32'h100,32'h300,32'h80, 0,32'h0,  32'h0,          0,0,0,32'h0);
        // ebreak with MIE already clear
        add(0,1,0,0,0,0, 32'h0,       32'h700,      32'h100,32'h0, 32'h80,  0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h700,      32'h100,32'h0, 32'h80,  1,32'h341,32'h700,        1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h700,      32'h100,32'h700,32'h80, 1,32'h342,32'd3,          1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h700,      32'h100,32'h700,32'h80, 1,32'h300,32'h0,          1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h700,      32'h100,32'h700,32'h0,  0,32'h0,  32'h0,          1,0,1,32'h100);
        add(0,0,0,0,0,0, 32'h0,       32'h100,      32'h100,32'h700,32'h0,  0,32'h0,  32'h0,          0,0,0,32'h0);
        // interrupt at top of address space: epc wraps to 0
        add(0,0,0,1,0,0, 32'h0,       32'hFFFFFFFC, 32'h100,32'h0, 32'h88,  0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'hFFFFFFFC, 32'h100,32'h0, 32'h88,  1,32'h341,32'h0,          1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'hFFFFFFFC, 32'h100,32'h0, 32'h88,  1,32'h342,32'h8000000B,   1,1,0,32'h0);
        add(0,0,0,1,0,0, 32'h0,       32'hFFFFFFFC, 32'h100,32'h0, 32'h88,  1,32'h300,32'h80,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'hFFFFFFFC, 32'h100,32'h0, 32'h80,  0,32'h0,  32'h0,          1,0,1,32'h100);
        add(0,0,0,0,0,0, 32'h0,       32'h100,      32'h100,32'h0, 32'h80,  0,32'h0,  32'h0,          0,0,0,32'h0);

        run_range("vec", 0, vq.size() - 1);

        // reset asserted during SAVE_CAUSE of an ecall entry
        vq.delete();
        add(1,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h0, 32'h8,   0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h0, 32'h8,   1,32'h341,32'h40,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h40,32'h8,   1,32'h342,32'd11,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h40,32'h8,   0,32'h0,  32'h0,          0,0,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h40,       32'h100,32'h40,32'h8,   0,32'h0,  32'h0,          0,0,0,32'h0);
        add(1,0,0,0,0,0, 32'h0,       32'h80,       32'h100,32'h40,32'h8,   0,32'h0,  32'h0,          0,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h80,       32'h100,32'h40,32'h8,   1,32'h341,32'h80,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h80,       32'h100,32'h80,32'h8,   1,32'h342,32'd11,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h80,       32'h100,32'h80,32'h8,   1,32'h300,32'h80,         1,1,0,32'h0);
        add(0,0,0,0,0,0, 32'h0,       32'h80,       32'h100,32'h80,32'h80,  0,32'h0,  32'h0,          1,0,1,32'h100);
        add(0,0,0,0,0,0, 32'h0,       32'h100,      32'h100,32'h80,32'h80,  0,32'h0,  32'h0,          0,0,0,32'h0);

        run_range("rst_seq", 0, 2);
        rst = 1'b1;
        #1;
        check("rst_async", 100'h0);
        @(posedge clk);
        #1;
        check("rst_held", 100'h0);
        @(negedge clk);
        rst = 1'b0;
        run_range("rst_seq", 3, vq.size() - 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap and pipeline-flow controller in front of `pc_reg` and `csr_reg`. It merges execute-stage jump/hold requests with trap events (ecall, ebreak, mret, external interrupt) and drives the single hold/jump request into `pc_reg`. During trap entry and exit it owns the CSR write port and sequences the mepc/mcause/mstatus updates, one per cycle, before redirecting the PC.

## Interface
- `XLEN`, 32, data/address width (matches `RegBus`).
- `MTVEC_MASK`, 32'hFFFF_FFFC, mask applied to mtvec to form the trap target (direct mode only).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ecall_i` in 1: ecall retiring in EX (1-cycle pulse).
- `ebreak_i` in 1: ebreak retiring in EX (1-cycle pulse).
- `mret_i` in 1: mret retiring in EX (1-cycle pulse).
- `int_req_i` in 1: machine external interrupt, level.
- `inst_addr_i` in XLEN: PC of the instruction in EX.
- `jump_flag_ex_i` in 1: branch/jump taken in EX.
- `jump_addr_ex_i` in XLEN: EX branch target.
- `hold_ex_i` in 1: EX multi-cycle stall request.
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i` in XLEN: direct read taps from `csr_reg`.
- `csr_we_o` out 1: CSR write enable (`Write`=1).
- `csr_waddr_o` out XLEN: CSR address (0x300 mstatus, 0x341 mepc, 0x342 mcause).
- `csr_wdata_o` out XLEN: CSR write data.
- `csr_busy_o` out 1: trap FSM owns the CSR port; EX CSR writes are blocked.
- `hold_flag_o` out 1: to `pc_reg.hold_flag_i`.
- `jump_flag_o` out 1: to `pc_reg.jump_flag_i`.
- `jump_addr_o` out XLEN: to `pc_reg.jump_addr_i`.

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RET_STATUS, JUMP.
- Event acceptance happens in IDLE only. Priority: ecall > ebreak > mret > interrupt.
  - An interrupt is taken only when `csr_mstatus_i[3]` (MIE)=1 and `hold_ex_i`=0.
  - Events arriving outside IDLE are dropped. Interrupt is level, so it is re-evaluated on return to IDLE.
- Trap entry: IDLE -> SAVE_EPC -> SAVE_CAUSE -> SAVE_STATUS -> JUMP -> IDLE.
  - Captured at the acceptance edge: epc and cause.
  - epc: ecall/ebreak give `inst_addr_i`. Interrupt gives `jump_addr_ex_i` if `jump_flag_ex_i`, else `inst_addr_i`+4 (mod 2^32).
  - cause: ecall 32'd11, ebreak 32'd3, interrupt 32'h8000_000B.
  - SAVE_EPC writes 0x341 = epc.
  - SAVE_CAUSE writes 0x342 = cause.
  - SAVE_STATUS writes 0x300 = `csr_mstatus_i` with bit7 (MPIE) = old bit3 and bit3 = 0.
  - JUMP target = `csr_mtvec_i & MTVEC_MASK`, sampled in JUMP.
- Trap exit: IDLE -> RET_STATUS -> JUMP -> IDLE.
  - RET_STATUS writes 0x300 = mstatus with bit3 = old bit7 and bit7 = 1.
  - JUMP target = `csr_mepc_i`, sampled in JUMP.
- `csr_we_o` is 1 only in SAVE_*/RET_STATUS. It is 0 (address/data 0) elsewhere.
- `csr_busy_o` = (state != IDLE).
- `hold_flag_o` = `hold_ex_i` OR (state != IDLE, excluding JUMP) OR (event accepted this cycle).
- `jump_flag_o`/`jump_addr_o`:
  - In JUMP: 1 / target.
  - In IDLE with no event accepted: pass-through of `jump_flag_ex_i`/`jump_addr_ex_i`.
  - Otherwise: 0/0. An EX jump coincident with an accepted trap is suppressed; for an interrupt it is recorded in epc.

## Timing
- Reset (async, any time, including mid-sequence): state=IDLE, captured epc/cause=0. All outputs 0 except pass-through terms, which follow the inputs combinationally. Any partial CSR sequence is abandoned.
- Trap entry accepted at cycle T:
  - Hold asserted T..T+3.
  - CSR writes at T+1 (mepc), T+2 (mcause), T+3 (mstatus).
  - `jump_flag_o`=1 at T+4. IDLE at T+5.
- mret accepted at T: hold T..T+1, mstatus write T+1, jump T+2, IDLE T+3.
- Outputs are combinational from state/captured registers/inputs. No added latency beyond the FSM.
- `csr_reg` write is visible on its read taps the cycle after `csr_we_o`. JUMP therefore sees the updated mtvec/mepc/mstatus.

## Test plan
- Ecall: mtvec=0x100, `inst_addr_i`=0x40, mstatus=0x8, pulse `ecall_i` -> mepc=0x40, mcause=11, mstatus=0x80 written on T+1..T+3; jump to 0x100 at T+4; hold T..T+3.
- Mret after the ecall: mepc=0x44, mstatus=0x80, pulse `mret_i` -> mstatus written 0x88 at T+1; jump to 0x44 at T+2.
- Interrupt with coincident EX jump (target 0x200), MIE=1 -> mepc=0x200, mcause=0x8000000B. Same-cycle `jump_flag_o`=0.
- Interrupt masked (MIE=0) or `hold_ex_i`=1 -> no CSR write. Pass-through only. Taken the first cycle both conditions clear.
- Ecall and `int_req_i` in the same cycle -> cause 11. Interrupt not taken afterwards because MIE is now 0.
- `rst` pulse at T+2 of an ecall entry -> outputs 0 immediately; no mstatus write; no jump; next ecall runs a full sequence.
